pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 20 ++
 rtl/pipe_perf_counter.sv | 19 +
 rtl/pipeline_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared codes for the pipeline controller: instruction opcodes that raise
// stalls/halts upstream, and the controller FSM state encodings.
package pipeline_ctrl_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam int unsigned STALL_W   = 32;
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_CTRL_WAIT = 2'd1,
    ST_MEM_WAIT  = 2'd2,
    ST_HALT      = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/pipe_perf_counter.sv
// Saturating stall-cycle counter used by pipeline_ctrl when PIPE_CTRL_PERF_EN is defined.
module pipe_perf_counter
  import pipeline_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  output logic [STALL_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != STALL_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush/halt controller. Optional stall-cycle counter is built
// only when the macro PIPE_CTRL_PERF_EN is defined; otherwise stall_cycles is 0.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               data_stall,
  input  logic               control_stall,
  input  logic               redirect_valid,
  input  logic               mem_req,
  input  logic               mem_ack,
  input  logic               halt_req,
  output logic               pc_en,
  output logic               if_en,
  output logic               alu_en,
  output logic               mem_en,
  output logic               wb_en,
  output logic               rr_bubble,
  output logic               if_flush,
  output logic               halted,
  output logic [STALL_W-1:0] stall_cycles,
  output ctrl_state_t        fsm_state
);

  ctrl_state_t state, saved, next_state, next_saved, eff_state;

  // Memory handshake: mem_req is held by MEM for as long as the access is
  // pending; the access completes in the first cycle mem_ack is high, and
  // that cycle is not frozen. Every cycle before it freezes the pipeline.
  always_comb begin
    pc_en      = 1'b0;
    if_en      = 1'b0;
    alu_en     = 1'b0;
    mem_en     = 1'b0;
    wb_en      = 1'b0;
    rr_bubble  = 1'b0;
    if_flush   = 1'b0;
    halted     = 1'b0;
    next_state = state;
    next_saved = saved;
    // On the ack cycle of a memory wait, behave as the state we froze in.
    eff_state  = (state == ST_MEM_WAIT) ? saved : state;
    if (rst) begin
      rr_bubble  = 1'b1;
      if_flush   = 1'b1;
      next_state = ST_RUN;
      next_saved = ST_RUN;
    end else if (halt_req || (state == ST_HALT)) begin
      halted     = 1'b1;
      next_state = ST_HALT;
    end else if (((state == ST_MEM_WAIT) || mem_req) && !mem_ack) begin
      next_state = ST_MEM_WAIT;
      if (state != ST_MEM_WAIT) next_saved = state;
    end else if (redirect_valid) begin
      {pc_en, if_en, alu_en, mem_en, wb_en} = 5'b11111;
      rr_bubble  = 1'b1;
      if_flush   = 1'b1;
      next_state = ST_RUN;
    end else if (eff_state == ST_CTRL_WAIT) begin
      {pc_en, if_en, alu_en, mem_en, wb_en} = 5'b01111;
      rr_bubble  = 1'b1;
      if_flush   = 1'b1;
      next_state = ST_CTRL_WAIT;
    end else if (control_stall) begin
      {pc_en, if_en, alu_en, mem_en, wb_en} = 5'b01111;
      if_flush   = 1'b1;
      next_state = ST_CTRL_WAIT;
    end else if (data_stall) begin
      {pc_en, if_en, alu_en, mem_en, wb_en} = 5'b00111;
      rr_bubble  = 1'b1;
      next_state = ST_RUN;
    end else begin
      {pc_en, if_en, alu_en, mem_en, wb_en} = 5'b11111;
      next_state = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      saved <= ST_RUN;
    end else begin
      state <= next_state;
      saved <= next_saved;
    end
  end

  assign fsm_state = state;

`ifdef PIPE_CTRL_PERF_EN
  pipe_perf_counter u_perf (
    .clk   (clk),
    .rst   (rst),
    .inc   (!pc_en && !halted),
    .count (stall_cycles)
  );
`else
  assign stall_cycles = '0;
`endif

endmodule
